// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional
// write-to-read forwarding and a per-register busy scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRD*ADDR_W-1:0]    rs_addr_i,
    output logic [NRD*DATA_W-1:0]    rs_data_o,
    output logic [NRD-1:0]           rs_busy_o,
    input  logic [NWR-1:0]           rd_wren_i,
    input  logic [NWR*ADDR_W-1:0]    rd_addr_i,
    input  logic [NWR*DATA_W-1:0]    rd_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic [ADDR_W-1:0] wr_addr [NWR];
    logic [DATA_W-1:0] wr_data [NWR];
    logic              wr_en   [NWR];
    logic [ADDR_W-1:0] rd_addr [NRD];
    logic [DATA_W-1:0] rd_data [NRD];
    logic              rd_busy [NRD];

    // Unpack flat port vectors; writes to x0 are squashed here once.
    for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
        assign wr_addr[j] = rd_addr_i[j*ADDR_W +: ADDR_W];
        assign wr_data[j] = rd_data_i[j*DATA_W +: DATA_W];
        assign wr_en[j]   = rd_wren_i[j] && (wr_addr[j] != '0);
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
        assign rd_addr[k]                      = rs_addr_i[k*ADDR_W +: ADDR_W];
        assign rs_data_o[k*DATA_W +: DATA_W]   = rd_data[k];
        assign rs_busy_o[k]                    = rd_busy[k];
    end

    // Scoreboard next state: writeback clears, flush beats alloc, alloc beats writeback.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end else if (alloc_en_i && (alloc_addr_i != '0)) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Storage; later ports are applied last so the highest index wins a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    regs_q[wr_addr[j]] <= wr_data[j];
                end
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read with optional forwarding; forwarded data is never busy.
    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_data[k] = regs_q[rd_addr[k]];
            rd_busy[k] = busy_q[rd_addr[k]];
            if ((BYPASS != 0) && !rst_i) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j] == rd_addr[k])) begin
                        rd_data[k] = wr_data[j];
                        rd_busy[k] = 1'b0;
                    end
                end
            end
            if (rd_addr[k] == '0) begin
                rd_data[k] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; next generation of the 2-read/1-write regfile.
- Configurable width, depth, read-port count and write-port count; optional write-to-read bypass; x0 hardwired to zero.
- Adds a per-register busy scoreboard: decode allocates a destination, writeback clears it. Hazard logic reads busy flags alongside operand data.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- rs_addr_i  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rs_data_o  out  NRD*DATA_W  read data per port, combinational
- rs_busy_o  out  NRD  busy flag per read port, combinational
- rd_wren_i  in  NWR  write enable per write port
- rd_addr_i  in  NWR*ADDR_W  write addresses
- rd_data_i  in  NWR*DATA_W  write data
- alloc_en_i  in  1  mark alloc_addr_i busy
- alloc_addr_i  in  ADDR_W  register being allocated by decode
- flush_i  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Storage: NREG x DATA_W data registers plus NREG busy bits. Register 0 is never written or marked busy. Reads of addr 0 return 0 with busy=0.
- Reset: rst_i=1 at a rising edge zeroes all data and busy bits. After that edge, every rs_data_o=0 and rs_busy_o=0.
  - While rst_i=1, writes, alloc and flush are ignored and bypass is suppressed. Outputs show stored state only.
- Write: on a rising edge with rd_wren_i[j]=1 and rd_addr_i[j]!=0, reg[addr] <= data. Single-cycle latency.
- Write collision (NWR=2, same nonzero address, both enabled): the higher-indexed port wins for both storage and bypass.
- Read: purely combinational. An address change shows new data in the same cycle with no clock.
  - BYPASS=1: if any enabled write port targets the read address this cycle (nonzero, rst_i=0), rs_data_o returns that write data, using the collision priority above.
  - BYPASS=0: rs_data_o returns the stored value; written data appears after the edge.
- Busy scoreboard, evaluated per register at each edge, priority high to low:
  1. rst_i: clear.
  2. flush_i: clear all; a same-cycle alloc is dropped.
  3. alloc_en_i with alloc_addr_i==r (r!=0): set. Alloc wins over a same-cycle write to r, because the newer producer is outstanding.
  4. Any enabled write to r: clear.
  5. Otherwise hold.
- rs_busy_o[k] = busy[rs_addr_k]. When BYPASS=1, a same-cycle enabled write to that address forces 0, so the flag stays consistent with the forwarded data. An alloc in the same cycle does not affect rs_busy_o until the next cycle.
- No handshake or backpressure: one write per port per cycle, always accepted.

Test Plan:
1. Reset, then write 0x13579BDF to x3 (port 0). Next cycle read x3 -> 0x13579BDF. Read x0 after a write of 0xFFFFFFFF to x0 -> 0x00000000.
2. BYPASS=1: in one cycle write x8=0x246 and read x8 -> rs_data_o=0x00000246 before the edge. BYPASS=0, same stimulus -> old value (0) before the edge, 0x246 after.
3. NWR=2: port0 writes x5=0x1, port1 writes x5=0x2 in the same cycle -> bypass and stored value are both 0x00000002.
4. Alloc x4 -> next cycle rs_busy=1. Write x4=0xFFFF1357 -> busy reads 0 in the same cycle with BYPASS=1, and busy=0 next cycle. Alloc x4 and write x4 in the same cycle -> busy=1 next cycle.
5. Alloc x6, x7 on consecutive cycles, then flush_i=1 together with alloc x9 -> x6, x7, x9 all read busy=0 after the edge.
6. Load x12=0x1317131F and mark it busy, then pulse rst_i for one edge -> all reads 0 and busy 0. A write presented while rst_i=1 is not stored.
